ripple_carry_adder32: RTL and testbench
=======================================

# ripple_carry_adder32

32-bit signed/unsigned ripple-carry adder with registered outputs, built as a chain of single-bit full adders. It produces a sum, carry-out and two's-complement overflow flag for the datapath's arithmetic stage. All results are captured in output registers, so downstream logic sees a clean, cycle-aligned result one clock after the operands are presented.

## Interface

Parameters:
- WIDTH, 32, operand and sum width in bits; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  WIDTH  operand A, two's complement (also valid as unsigned).
- b  input  WIDTH  operand B, two's complement (also valid as unsigned).
- cin  input  1  carry into bit 0.
- in_valid  input  1  operands valid this cycle; capture enable.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- overflow  output  1  registered signed overflow flag.
- out_valid  output  1  registered; high for one cycle per accepted operand set.

## Operation

- Adder core is purely structural: WIDTH full-adder cells in a generate loop, c[0] = cin, c[i+1] = carry of cell i.
- Full-adder cell: s = a ^ b ^ c; co = (a & b) | (c & (a ^ b)).
- No lookahead, no `+` operator in the core; carry ripples bit 0 to bit WIDTH-1.
- cout = c[WIDTH].
- overflow = c[WIDTH] ^ c[WIDTH-1]. It is high exactly when a and b have the same sign and the sum's sign differs.
- sum wraps modulo 2^WIDTH. The registered result is the wrapped value even when overflow = 1. For example, 0x7FFFFFFF + 1 → 0x80000000.
- cin participates in both carry-out and overflow computation.
  - Example: 0x7FFFFFFF + 0 + cin=1 → sum 0x80000000, overflow 1.
- Capture rules:
  - When in_valid = 1 at a rising edge, sum/cout/overflow load the core result and out_valid is set to 1.
  - When in_valid = 0, sum/cout/overflow hold their previous values and out_valid is set to 0.

## Timing

- Reset: on a rising clk edge with rst_n = 0, sum = 0, cout = 0, overflow = 0 and out_valid = 0.
- Reset has priority over in_valid. Operands presented during a reset cycle are discarded.
- Latency: 1 cycle. Operands sampled at edge N appear on the outputs after edge N, with out_valid = 1 during cycle N+1.
- Throughput: one addition per cycle. Back-to-back in_valid is fully supported with no bubbles.
- No backpressure: there is no ready signal, and the consumer must accept out_valid pulses.
- Combinational critical path is a full WIDTH-bit carry ripple from cin/a[0]/b[0] to the output register D inputs.
- Reset deasserting mid-stream: the first capture occurs at the first edge with rst_n = 1 and in_valid = 1.

## Test plan

All cases use cin = 0 unless stated. Apply stimulus with in_valid = 1 and check the outputs one cycle later with out_valid = 1.

- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 and random operands → sum = 0, cout = 0, overflow = 0, out_valid = 0. Release reset → the first result appears one cycle after.
- Positive overflow: a = 2147483647, b = 1 → sum = -2147483648 (0x80000000), overflow = 1, cout = 0.
- Negative overflow: a = -2147483648, b = -1 → sum = 2147483647, overflow = 1, cout = 1.
- Mixed-sign, no overflow, back-to-back on consecutive cycles, each with overflow = 0:
  - 52 + -31 → 21
  - -451 + 4498 → 4047
  - 4561 + -89 → 4472
- Same-sign, no overflow, each with overflow = 0:
  - 152 + 2539 → 2691
  - -495955 + -4548 → -500503, cout = 1
  - 0 + 0 → 0, cout = 0
- Carry-in and hold:
  - a = 0xFFFFFFFF, b = 0, cin = 1 → sum = 0, cout = 1, overflow = 0.
  - Then drop in_valid for 3 cycles while changing operands → outputs hold those values and out_valid = 0.

Source files
------------

// File: rtl/ripple_carry_adder32.sv
// Registered ripple-carry adder: WIDTH single-bit full-adder cells chained bit 0 upward,
// with sum, carry-out and signed overflow captured one cycle after in_valid.

module rca_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & p);
endmodule

module ripple_carry_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_p0;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  assign c[0] = cin;

  // Stage p0: structural carry ripple, bit 0 to bit WIDTH-1
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rca_full_adder u_fa (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .c_i  (c[i]),
      .s_o  (s_p0[i]),
      .co_o (c[i+1])
    );
  end

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      sum_d  = s_p0;
      cout_d = c[WIDTH];
      // Carry into and out of the sign bit disagree only on signed overflow
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      vld_d  = 1'b1;
    end
  end

  // Stage p1: output registers; reset takes priority over a capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_ripple_carry_adder32.sv
// Directed and random stimulus for ripple_carry_adder32, with expected results queued
// at drive time and popped when the registered outputs appear.

module tb_ripple_carry_adder32;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        cin, in_valid;
  logic [31:0] sum;
  logic        cout, overflow, out_valid;

  res_t q[$];
  res_t last;
  int   errors = 0;
  int   checks = 0;

  ripple_carry_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    res_t r;
    t    = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    r.s  = t[31:0];
    r.co = t[32];
    r.ov = (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  // One clock: drive at negedge, check 1 time unit after the rising edge.
  task automatic step(input string tag, input logic rst_v, input logic [31:0] ta,
                      input logic [31:0] tb_, input logic tc, input logic tv,
                      input logic use_exp, input res_t ex);
    res_t e;
    logic exp_vld;
    @(negedge clk);
    rst_n = rst_v; a = ta; b = tb_; cin = tc; in_valid = tv;
    exp_vld = tv && rst_v;
    if (exp_vld) q.push_back(use_exp ? ex : model(ta, tb_, tc));
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, exp_vld});
    if (!rst_v) begin
      last = '0;
      e = '0;
    end else if (exp_vld) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s.queue: observed empty expected entry", tag);
        e = last;
      end else begin
        e = q.pop_front();
        last = e;
      end
    end else begin
      e = last;
    end
    chk({tag, ".sum"}, sum, e.s);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, e.co});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.ov});
  endtask

  function automatic res_t R(input logic [31:0] s, input logic co, input logic ov);
    res_t r;
    r.s = s; r.co = co; r.ov = ov;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    last = '0;

    // Reset held two cycles with live operands
    step("rst0", 1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0, '0);
    step("rst1", 1'b0, $urandom, $urandom, 1'b1, 1'b1, 1'b0, '0);

    // First capture right after reset release
    step("pos_ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, R(32'h8000_0000, 1'b0, 1'b1));
    step("neg_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, R(32'h7FFF_FFFF, 1'b1, 1'b1));

    // Mixed sign, back to back
    step("mix0", 1'b1, 32'sd52, -32'sd31, 1'b0, 1'b1, 1'b1, R(32'd21, 1'b1, 1'b0));
    step("mix1", 1'b1, -32'sd451, 32'sd4498, 1'b0, 1'b1, 1'b1, R(32'd4047, 1'b1, 1'b0));
    step("mix2", 1'b1, 32'sd4561, -32'sd89, 1'b0, 1'b1, 1'b1, R(32'd4472, 1'b1, 1'b0));

    // Same sign
    step("same0", 1'b1, 32'sd152, 32'sd2539, 1'b0, 1'b1, 1'b1, R(32'd2691, 1'b0, 1'b0));
    step("same1", 1'b1, -32'sd495955, -32'sd4548, 1'b0, 1'b1, 1'b1, R(-32'sd500503, 1'b1, 1'b0));
    step("same2", 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, R(32'd0, 1'b0, 1'b0));

    // Carry-in cases
    step("cin_wrap", 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1, R(32'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step("hold", 1'b1, $urandom, $urandom, 1'(i), 1'b0, 1'b0, '0);
    step("cin_ovf", 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1, R(32'h8000_0000, 1'b0, 1'b1));

    // Random operands with occasional gaps
    for (int i = 0; i < 40; i++)
      step("rand", 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'b0, '0);

    // Reset mid-stream, then resume
    step("mrst", 1'b0, $urandom, $urandom, 1'b0, 1'b1, 1'b0, '0);
    step("post_idle", 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, '0);
    step("post_cap", 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, R(32'h0001_0000, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
